// File: rtl/pim_pkg.sv
// Shared definitions for the PIM controller: FSM states, window offsets and
// the onehot macro-select decode used by the address decoder.
package pim_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWload,
        StAload,
        StCompute,
        StDone
    } pim_state_e;

    // Offsets inside the PIM window (relative to BASE_ADDR)
    localparam logic [7:0] STATUS_OFS = 8'h10;
    localparam logic [7:0] RESULT_OFS = 8'h20;
    localparam logic [7:0] WEIGHT_OFS = 8'h40;
    localparam logic [7:0] ACT_OFS    = 8'h80;

    typedef struct packed {
        logic       legal;
        logic [1:0] idx;
    } sel_dec_t;

    // Onehot nibble -> macro index; legal only for a single set bit that
    // addresses an instantiated macro.
    function automatic sel_dec_t decode_sel(input logic [3:0] onehot,
                                            input int unsigned num_macro);
        sel_dec_t res;
        res.legal = 1'b1;
        res.idx   = 2'd0;
        case (onehot)
            4'b0001: res.idx = 2'd0;
            4'b0010: res.idx = 2'd1;
            4'b0100: res.idx = 2'd2;
            4'b1000: res.idx = 2'd3;
            default: res.legal = 1'b0;
        endcase
        if ({30'd0, res.idx} >= num_macro) begin
            res.legal = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/pim_sel_decode.sv
// Macro-select decoder: onehot address nibble to macro index plus an illegal
// flag, limited to the number of macros actually present.
module pim_sel_decode
    import pim_pkg::*;
#(
    parameter int unsigned NUM_MACRO = 4
) (
    input  logic [3:0] onehot,
    output logic [1:0] sel,
    output logic       illegal
);

    sel_dec_t dec;

    // Pure combinational decode through the shared package function
    always_comb begin
        dec     = decode_sel(onehot, NUM_MACRO);
        sel     = dec.idx;
        illegal = ~dec.legal;
    end

endmodule

// File: rtl/pim_controller_mc.sv
// Multi-macro PIM controller. Turns bus accesses inside the PIM window into
// weight-row, activation-group, compute and result-buffer strobes.
// Optional completion interrupt built only when PIM_IRQ_EN is defined;
// otherwise o_irq is tied low.
module pim_controller_mc
    import pim_pkg::*;
#(
    parameter int unsigned NUM_MACRO   = 4,
    parameter int unsigned WL_DEPTH    = 288,
    parameter int unsigned WGT_BEATS   = 16,
    parameter int unsigned ACT_BEATS   = 9,
    parameter int unsigned COMPUTE_LAT = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [31:0]                 i_address,
    input  logic                        i_req,
    output logic                        o_weight_in_en,
    output logic                        o_weight_out_en,
    output logic [$clog2(WL_DEPTH)-1:0] o_WL_address,
    output logic                        o_activation_in_en,
    output logic                        o_activation_out_en,
    output logic [1:0]                  o_sel,
    output logic                        o_result_in_en,
    output logic                        o_result_out_en,
    output logic                        o_result_buffer_busy,
    output logic [7:0]                  o_counter,
    output logic                        o_busy,
    output logic                        o_valid,
    output logic                        o_pim_status_read,
    output logic                        o_err,
    output logic                        o_irq
);

    localparam int unsigned     WL_W     = $clog2(WL_DEPTH);
    localparam logic [WL_W-1:0] WL_LAST  = WL_W'(WL_DEPTH - 1);
    localparam logic [7:0]      WGT_LAST = 8'(WGT_BEATS - 1);
    localparam logic [7:0]      ACT_LAST = 8'(ACT_BEATS - 1);
    localparam logic [7:0]      LAT_LAST = 8'(COMPUTE_LAT - 1);

    pim_state_e      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [WL_W-1:0] wl_q, wl_d;
    logic [1:0]      sel_q, sel_d;
    logic            valid_q, err_q, result_out_q, status_rd_q;

    logic [31:0] offset;
    logic        in_low;
    logic        status_acc, result_acc, wgt_acc, act_acc;
    logic [1:0]  dec_sel;
    logic        dec_illegal;
    logic        wgt_ok, act_ok, bad;
    logic        result_rd, result_rd_last;
    logic        fsm_err, err_event;
    logic        weight_in_en, weight_out_en, act_in_en, act_out_en, result_in_en;

    assign offset     = i_address - BASE_ADDR;
    assign in_low     = (offset[31:8] == 24'h0);
    assign status_acc = i_req && in_low && (offset[7:0] == STATUS_OFS);
    assign result_acc = i_req && in_low && (offset[7:4] == RESULT_OFS[7:4]);
    assign wgt_acc    = i_req && in_low && (offset[7:4] == WEIGHT_OFS[7:4]);
    assign act_acc    = i_req && in_low && (offset[7:4] == ACT_OFS[7:4]);

    pim_sel_decode #(
        .NUM_MACRO (NUM_MACRO)
    ) u_sel_decode (
        .onehot  (offset[3:0]),
        .sel     (dec_sel),
        .illegal (dec_illegal)
    );

    assign wgt_ok = wgt_acc & ~dec_illegal;
    assign act_ok = act_acc & ~dec_illegal;
    assign bad    = (wgt_acc | act_acc) & dec_illegal;

    // Reads only count while a result is held, so a read coinciding with the
    // capture strobe is ignored.
    assign result_rd      = result_acc & valid_q;
    assign result_rd_last = result_rd & (offset[3:0] == 4'hF);

    // Next-state, counters and same-cycle strobes
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wl_d          = wl_q;
        sel_d         = sel_q;
        fsm_err       = 1'b0;
        weight_in_en  = 1'b0;
        weight_out_en = 1'b0;
        act_in_en     = 1'b0;
        act_out_en    = 1'b0;
        result_in_en  = 1'b0;
        case (state_q)
            StIdle, StDone, StWload: begin
                if (wgt_ok) begin
                    weight_in_en = 1'b1;
                    sel_d        = dec_sel;
                    state_d      = StWload;
                    if (cnt_q == WGT_LAST) begin
                        weight_out_en = 1'b1;
                        cnt_d         = 8'd0;
                        wl_d          = (wl_q == WL_LAST) ? '0 : wl_q + WL_W'(1);
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (act_ok && state_q != StWload) begin
                    act_in_en = 1'b1;
                    sel_d     = dec_sel;
                    state_d   = StAload;
                    if (cnt_q == ACT_LAST) begin
                        act_out_en = 1'b1;
                        cnt_d      = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (bad) begin
                    // illegal write dropped, state held
                end else if (state_q == StWload) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                    wl_d    = '0;
                end else if (state_q == StDone && result_rd_last) begin
                    state_d = StIdle;
                end
            end
            StAload: begin
                if (act_ok) begin
                    act_in_en = 1'b1;
                    sel_d     = dec_sel;
                    if (cnt_q == ACT_LAST) begin
                        act_out_en = 1'b1;
                        cnt_d      = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (bad) begin
                    // illegal write dropped, state held
                end else if (wgt_ok) begin
                    fsm_err = 1'b1;
                end else if (cnt_q == 8'd0) begin
                    state_d = StCompute;
                end else begin
                    // partial activation group: abandon without computing
                    fsm_err = 1'b1;
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end
            end
            StCompute: begin
                if (wgt_ok) begin
                    fsm_err = 1'b1;
                end
                if (cnt_q == LAT_LAST) begin
                    result_in_en = 1'b1;
                    cnt_d        = 8'd0;
                    state_d      = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
                wl_d    = '0;
            end
        endcase
    end

    assign err_event = bad | fsm_err;

    // State, counters, select and the registered status/result handshakes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            wl_q         <= '0;
            sel_q        <= 2'd0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            result_out_q <= 1'b0;
            status_rd_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wl_q         <= wl_d;
            sel_q        <= sel_d;
            result_out_q <= result_rd;
            status_rd_q  <= status_acc;
            if (result_in_en) begin
                valid_q <= 1'b1;
            end else if (result_rd_last) begin
                valid_q <= 1'b0;
            end
            // a new error outranks the clear from a status read
            if (err_event) begin
                err_q <= 1'b1;
            end else if (status_acc) begin
                err_q <= 1'b0;
            end
        end
    end

`ifdef PIM_IRQ_EN
    logic irq_q;

    // Completion interrupt: set with the result capture, cleared by a status
    // read or the final result word read. irq_q doubles as status bit 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_q <= 1'b0;
        end else if (result_in_en) begin
            irq_q <= 1'b1;
        end else if (status_acc || result_rd_last) begin
            irq_q <= 1'b0;
        end
    end

    assign o_irq = irq_q;
`else
    assign o_irq = 1'b0;
`endif

    assign o_weight_in_en       = weight_in_en;
    assign o_weight_out_en      = weight_out_en;
    assign o_WL_address         = wl_q;
    assign o_activation_in_en   = act_in_en;
    assign o_activation_out_en  = act_out_en;
    assign o_sel                = sel_q;
    assign o_result_in_en       = result_in_en;
    assign o_result_out_en      = result_out_q;
    assign o_result_buffer_busy = valid_q | result_in_en | result_acc;
    assign o_counter            = cnt_q;
    assign o_busy               = (state_q != StIdle && state_q != StDone) ||
                                  result_rd || result_out_q;
    assign o_valid              = valid_q;
    assign o_pim_status_read    = status_rd_q;
    assign o_err                = err_q;

endmodule

// File: tb/tb_pim_controller_mc.sv
// Directed bench for pim_controller_mc: weight rows, row wrap, compute path,
// error cases, async reset mid-compute and the optional interrupt.
module tb_pim_controller_mc;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;

    logic       weight_in_en, weight_out_en, act_in_en, act_out_en;
    logic [8:0] wl_address;
    logic [1:0] sel;
    logic       result_in_en, result_out_en, rbuf_busy, busy, valid, status_rd, err, irq;
    logic [7:0] counter;

    logic       d2_weight_in_en, d2_weight_out_en, d2_act_in_en, d2_act_out_en;
    logic [8:0] d2_wl_address;
    logic [1:0] d2_sel;
    logic       d2_result_in_en, d2_result_out_en, d2_rbuf_busy, d2_busy, d2_valid;
    logic       d2_status_rd, d2_err, d2_irq;
    logic [7:0] d2_counter;

    int n_checks = 0;
    int n_fail   = 0;

    logic exp_irq;

    pim_controller_mc u_dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_address            (addr),
        .i_req                (req),
        .o_weight_in_en       (weight_in_en),
        .o_weight_out_en      (weight_out_en),
        .o_WL_address         (wl_address),
        .o_activation_in_en   (act_in_en),
        .o_activation_out_en  (act_out_en),
        .o_sel                (sel),
        .o_result_in_en       (result_in_en),
        .o_result_out_en      (result_out_en),
        .o_result_buffer_busy (rbuf_busy),
        .o_counter            (counter),
        .o_busy               (busy),
        .o_valid              (valid),
        .o_pim_status_read    (status_rd),
        .o_err                (err),
        .o_irq                (irq)
    );

    pim_controller_mc #(
        .NUM_MACRO (2)
    ) u_dut2 (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_address            (addr),
        .i_req                (req),
        .o_weight_in_en       (d2_weight_in_en),
        .o_weight_out_en      (d2_weight_out_en),
        .o_WL_address         (d2_wl_address),
        .o_activation_in_en   (d2_act_in_en),
        .o_activation_out_en  (d2_act_out_en),
        .o_sel                (d2_sel),
        .o_result_in_en       (d2_result_in_en),
        .o_result_out_en      (d2_result_out_en),
        .o_result_buffer_busy (d2_rbuf_busy),
        .o_counter            (d2_counter),
        .o_busy               (d2_busy),
        .o_valid              (d2_valid),
        .o_pim_status_read    (d2_status_rd),
        .o_err                (d2_err),
        .o_irq                (d2_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one bus cycle; combinational outputs are valid on return
    task automatic drive(input logic req_v, input logic [31:0] ofs);
        @(negedge clk);
        req  = req_v;
        addr = BASE + ofs;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, beats, seen;
        logic [31:0] mask;
        logic [8:0]  wl_at_last;

`ifdef PIM_IRQ_EN
        exp_irq = 1'b1;
`else
        exp_irq = 1'b0;
`endif

        // Reset state
        rst_n = 1'b0;
        req   = 1'b0;
        addr  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_counter", counter, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_wl", wl_address, 0);
        check_eq("rst_irq", irq, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Weight load: 32 beats to macro 1
        pulses = 0; beats = 0; mask = 0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 32'h42);
            if (weight_in_en) beats++;
            if (weight_out_en) begin
                pulses++;
                mask[i] = 1'b1;
            end
            if (i == 16) check_eq("wl_mid", wl_address, 1);
        end
        check_eq("wgt_beats", beats, 32);
        check_eq("wgt_rows", pulses, 2);
        check_eq("wgt_row_mask", mask, 32'h8000_8000);
        drive(1'b0, 32'h0);
        check_eq("wl_after", wl_address, 2);
        check_eq("wgt_sel", sel, 1);
        check_eq("wgt_cnt", counter, 0);
        check_eq("wgt_busy", busy, 1);
        drive(1'b0, 32'h0);
        check_eq("wl_idle", wl_address, 0);
        check_eq("idle_busy", busy, 0);

        // Row wrap: 288 rows of 16 beats to macro 0
        pulses = 0; wl_at_last = 0;
        for (int i = 0; i < 288 * 16; i++) begin
            drive(1'b1, 32'h41);
            if (weight_out_en) pulses++;
            if (i == 288 * 16 - 1) wl_at_last = wl_address;
        end
        check_eq("wrap_rows", pulses, 288);
        check_eq("wrap_wl_last", wl_at_last, 287);
        drive(1'b0, 32'h0);
        check_eq("wrap_wl_zero", wl_address, 0);
        check_eq("wrap_sel", sel, 0);
        drive(1'b0, 32'h0);

        // Compute path: 9 activation beats to macro 2
        beats = 0; mask = 0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'h84);
            if (act_in_en) beats++;
            if (act_out_en) mask[i] = 1'b1;
        end
        check_eq("act_beats", beats, 9);
        check_eq("act_group_mask", mask, 32'h100);
        // wait with a result read pending each cycle; must be ignored
        seen = 0;
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, 32'h2F);
            if (result_in_en) begin
                seen = k;
                check_eq("capture_valid", valid, 0);
                check_eq("capture_cnt", counter, 7);
                check_eq("capture_busy", busy, 1);
                break;
            end
        end
        check_eq("compute_latency", seen, 9);
        drive(1'b1, 32'h10);
        check_eq("done_valid", valid, 1);
        check_eq("early_read_ignored", result_out_en, 0);
        check_eq("done_busy", busy, 0);
        check_eq("done_sel", sel, 2);
        check_eq("irq_set", irq, exp_irq);
        pulses = 0;
        for (int n = 0; n < 16; n++) begin
            drive(1'b1, 32'h20 + n);
            if (n == 0) begin
                check_eq("status_rd", status_rd, 1);
                check_eq("irq_cleared", irq, 0);
                check_eq("read_busy", busy, 1);
                check_eq("read_rbuf_busy", rbuf_busy, 1);
            end else if (result_out_en) begin
                pulses++;
            end
        end
        drive(1'b0, 32'h0);
        if (result_out_en) pulses++;
        check_eq("result_reads", pulses, 16);
        check_eq("valid_cleared", valid, 0);
        drive(1'b0, 32'h0);
        check_eq("post_read_busy", busy, 0);
        check_eq("post_read_out_en", result_out_en, 0);
        check_eq("post_read_err", err, 0);

        // Non-onehot weight write
        drive(1'b1, 32'h43);
        check_eq("bad_wgt_in_en", weight_in_en, 0);
        check_eq("bad_act_in_en", act_in_en, 0);
        drive(1'b0, 32'h0);
        check_eq("bad_err", err, 1);
        check_eq("bad_cnt", counter, 0);
        check_eq("bad_busy", busy, 0);

        // Status read clears the error
        drive(1'b1, 32'h10);
        drive(1'b0, 32'h0);
        check_eq("clr_status_rd", status_rd, 1);
        check_eq("clr_err", err, 0);
        check_eq("clr_err_d2", d2_err, 0);

        // Macro 3 out of range when only two macros exist
        drive(1'b1, 32'h48);
        check_eq("m3_in_en", weight_in_en, 1);
        check_eq("m3_in_en_d2", d2_weight_in_en, 0);
        drive(1'b0, 32'h0);
        check_eq("m3_err_d2", d2_err, 1);
        check_eq("m3_err", err, 0);
        drive(1'b0, 32'h0);

        // Partial activation group
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h81);
        drive(1'b0, 32'h0);
        drive(1'b0, 32'h0);
        check_eq("partial_err", err, 1);
        check_eq("partial_cnt", counter, 0);
        check_eq("partial_busy", busy, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 32'h0);
            if (result_in_en) pulses++;
        end
        check_eq("partial_no_compute", pulses, 0);
        drive(1'b1, 32'h10);
        drive(1'b0, 32'h0);

        // Async reset mid-compute at counter 4
        for (int i = 0; i < 9; i++) drive(1'b1, 32'h84);
        seen = 0;
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 32'h0);
            if (counter == 8'd4 && busy) begin
                seen = k;
                break;
            end
        end
        check_eq("reach_cnt4", seen, 6);
        rst_n = 1'b0;
        #1;
        check_eq("ar_counter", counter, 0);
        check_eq("ar_busy", busy, 0);
        check_eq("ar_sel", sel, 0);
        check_eq("ar_valid", valid, 0);
        check_eq("ar_in_en", result_in_en, 0);
        check_eq("ar_irq", irq, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 32'h0);
            if (result_in_en || busy) pulses++;
        end
        check_eq("ar_idle_after", pulses, 0);
        drive(1'b1, 32'h41);
        check_eq("ar_restart_in_en", weight_in_en, 1);
        drive(1'b0, 32'h0);
        drive(1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pim_controller_mc.md
# pim_controller_mc

Parametrised, multi-macro successor to the single-sequence PIM controller. It sits between the system bus address decode and the PIM macro array. It turns bus accesses inside the PIM window into weight-row, activation-group, compute and result-buffer strobes for up to four macros. Over the first generation it adds an explicit state machine, parametrised geometry and compute latency, a sticky error flag and an optional completion interrupt.

## Interface
Parameters:
- NUM_MACRO, 4: number of PIM macros, 1..4.
- WL_DEPTH, 288: word lines per macro.
- WGT_BEATS, 16: bus writes per word-line row.
- ACT_BEATS, 9: bus writes per activation group.
- COMPUTE_LAT, 8: cycles from activation end to result capture, 2..255.
- BASE_ADDR, 32'h4000_0000: PIM window base.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_address  in  32  bus address.
- i_req  in  1  bus access valid this cycle.
- o_weight_in_en  out  1  weight beat accepted.
- o_weight_out_en  out  1  row complete; commit row to macro.
- o_WL_address  out  $clog2(WL_DEPTH)  target word line.
- o_activation_in_en  out  1  activation beat accepted.
- o_activation_out_en  out  1  activation group complete.
- o_sel  out  2  selected macro index.
- o_result_in_en  out  1  capture macro outputs into result buffer.
- o_result_out_en  out  1  result word driven to bus.
- o_result_buffer_busy  out  1  result buffer owned or being written.
- o_counter  out  8  beat or latency counter.
- o_busy  out  1  controller not idle.
- o_valid  out  1  unread result present.
- o_pim_status_read  out  1  status register read (registered).
- o_err  out  1  sticky error.
- o_irq  out  1  completion interrupt (macro-dependent).

## Operation
- Address map, offset = i_address − BASE_ADDR:
  - 0x10: status.
  - 0x20..0x2F: result words.
  - 0x40|onehot[3:0]: weight write.
  - 0x80|onehot[3:0]: activation write.
- Only accesses with i_req=1 act. Onehot bit k selects macro k.
- A weight or activation write is illegal if its onehot is not one-hot, or if it selects k ≥ NUM_MACRO. An illegal write sets o_err, is dropped, and causes no strobe and no state change.
- States: IDLE, WLOAD, ALOAD, COMPUTE, DONE.
- IDLE:
  - Legal weight write → WLOAD.
  - Legal activation write → ALOAD.
- WLOAD:
  - Each weight beat: o_weight_in_en=1 (combinational) and o_counter increments.
  - On the beat where o_counter == WGT_BEATS−1: o_weight_out_en=1, o_counter→0, and o_WL_address increments.
  - o_WL_address wraps from WL_DEPTH−1 to 0.
  - First cycle with no weight write → IDLE; o_WL_address→0 and o_counter→0.
- ALOAD:
  - Each beat: o_activation_in_en=1.
  - On o_counter == ACT_BEATS−1: o_activation_out_en=1 and o_counter→0.
  - First cycle with no activation write:
    - o_counter==0 → COMPUTE.
    - otherwise (partial group) → o_err set, → IDLE, no compute.
- COMPUTE:
  - o_counter counts from 0.
  - At o_counter == COMPUTE_LAT−1: o_result_in_en=1 for one cycle → DONE.
- DONE:
  - o_valid=1 and the result buffer is held.
  - A read of 0x20+n produces o_result_out_en one cycle later.
  - A read of offset 0x2F clears o_valid → IDLE.
  - A weight or activation write while in DONE is accepted: the state moves to WLOAD or ALOAD and o_valid is kept.
- Weight writes during ALOAD or COMPUTE: o_err set, write dropped.
- Status read: o_pim_status_read=1 the next cycle and o_err is cleared. If a new error event occurs in the same cycle, it wins and o_err stays set.
- o_sel holds the index of the last legal write.
- o_busy = 1 in any state other than IDLE and DONE, or whenever a result read is in progress.
- o_result_buffer_busy = o_valid | o_result_in_en | result-window access.

## Timing
- All outputs reset to 0.
- Reset takes effect immediately, including mid-operation; state → IDLE.
- Combinational (same cycle as the access): in_en strobes, weight/activation out_en strobes.
- Registered (one cycle after the access): o_result_out_en, o_pim_status_read.
- Latency from the last activation beat to o_result_in_en: COMPUTE_LAT+1 cycles.
- o_valid rises in the cycle after o_result_in_en.
- A result read in the same cycle as o_result_in_en is ignored.

## Configuration
- PIM_IRQ_EN defined:
  - o_irq rises with o_valid and stays high until a status read or the read of 0x2F, whichever comes first.
  - Status bit 0 reports irq-pending.
- PIM_IRQ_EN undefined: o_irq tied 0 and no irq logic is built.

## Structure
- Shared package pim_pkg holds:
  - state enum.
  - address offsets: STATUS_OFS, RESULT_OFS, WEIGHT_OFS, ACT_OFS.
  - select-decode function (onehot → index + legal flag).
- One sub-module, pim_sel_decode: onehot address nibble → o_sel index and illegal flag, gated by NUM_MACRO.

## Test plan
- Weight load, default parameters: 32 legal writes to 0x4000_0042 → two o_weight_out_en pulses; o_WL_address 0→1→2; o_sel=1. Then idle → o_WL_address=0.
- Row wrap: 288×16 writes to 0x4000_0041 → o_WL_address returns to 0 after the 288th row commit.
- Compute path: 9 writes to 0x4000_0084, then idle → o_activation_out_en on beat 9; o_result_in_en 9 cycles after that beat; o_valid=1. Reads 0x4000_0020..2F → 16 o_result_out_en pulses; o_valid=0 after the 0x2F read.
- Errors:
  - Write 0x4000_0043 → o_err=1 with no strobes.
  - With NUM_MACRO=2, write 0x4000_0048 → o_err=1.
  - 5 activation beats then idle → o_err=1, no o_result_in_en.
  - Status read clears o_err.
- Async reset asserted during COMPUTE at o_counter=4 → all outputs 0 immediately; after release, state is IDLE.
- With PIM_IRQ_EN: compute completes → o_irq=1; status read → o_irq=0. Without the macro, o_irq stays 0 throughout.
